spi_job_master: RTL and testbench

SPI mode-0 master that shifts a 768-bit mining job (256-bit midstate followed by 512-bit block_2) out to the miner's SPI slave port. It captures the slave's acknowledge byte returned on MISO. It sits on the host/controller side of the link: it takes a latched job word and a start pulse, and drives cs_n, sclk and mosi directly. The first payload bit goes first, index 0, matching the slave's `[0:767]` ordering.

---
 rtl/spi_link_pkg.sv | 20 ++
 rtl/spi_half_period_timer.sv | 36 +++
 rtl/spi_job_master.sv | 170 +++++++++++++++++
 tb/tb_spi_job_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_link_pkg.sv
// Shared definitions for the host-side SPI job link: job geometry, the slave's
// fixed acknowledge byte and the master FSM state encoding.
package spi_link_pkg;

  localparam int MIDSTATE_BITS = 256;
  localparam int BLOCK_BITS    = 512;
  localparam int JOB_BITS      = MIDSTATE_BITS + BLOCK_BITS;

  localparam logic [7:0] ACK_EXPECTED = 8'hA2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCK_HI,
    ST_SCK_LO,
    ST_HOLD,
    ST_GAP
  } spi_master_state_t;

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter: after a load, expire_o rises on the CLK_DIV-th cycle
// and stays high until the next load.
module spi_half_period_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expire_o
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/spi_job_master.sv
// SPI mode-0 master: shifts a job payload out index 0 first and captures the
// slave's leading acknowledge bits. Define SPI_JOB_MASTER_ACK_CHECK_EN for ack_err.
module spi_job_master
  import spi_link_pkg::*;
#(
  parameter int PAYLOAD_BITS = JOB_BITS,
  parameter int CLK_DIV      = 4,
  parameter int ACK_BITS     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [0:PAYLOAD_BITS-1] payload,
  output logic                    busy,
  output logic                    done,
  output logic                    cs_n,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso,
  output logic [0:ACK_BITS-1]     ack_word,
  output logic                    ack_err
);

  localparam int BW = $clog2(PAYLOAD_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW:0]   ACK_LIM  = (BW + 1)'(ACK_BITS);

  spi_master_state_t state_q, state_d;

  logic                    ent_q;
  logic                    tmr_load, tmr_exp;
  logic                    accept, hi_to_lo, ack_sample;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    last_q, last_d;
  logic [0:PAYLOAD_BITS-1] sh_q, sh_d;
  logic [0:ACK_BITS-1]     ack_q, ack_d;

  // Every state change restarts the half-period count.
  assign tmr_load   = (state_d != state_q);
  assign accept     = (state_q == ST_IDLE) && start;
  assign hi_to_lo   = (state_q == ST_SCK_HI) && (state_d == ST_SCK_LO);
  assign ack_sample = (state_q == ST_SCK_HI) && ent_q && ({1'b0, bit_q} < ACK_LIM);

  spi_half_period_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .expire_o (tmr_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ent_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ent_q   <= tmr_load;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start)   state_d = ST_SETUP;
      ST_SETUP:  if (tmr_exp) state_d = ST_SCK_HI;
      ST_SCK_HI: if (tmr_exp) state_d = ST_SCK_LO;
      ST_SCK_LO: if (tmr_exp) state_d = last_q ? ST_HOLD : ST_SCK_HI;
      ST_HOLD:   if (tmr_exp) state_d = ST_GAP;
      ST_GAP:    if (tmr_exp) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b1;
    done = 1'b0;
    cs_n = 1'b0;
    sclk = 1'b0;
    mosi = sh_q[0];
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
      end
      ST_SCK_HI: sclk = 1'b1;
      ST_GAP: begin
        cs_n = 1'b1;
        mosi = 1'b0;
        done = ent_q;
      end
      default: ;
    endcase
  end

  // The next bit is presented on the falling-edge transition itself, so mosi is
  // stable for the whole low half-period before the following rise.
  always_comb begin
    bit_d  = bit_q;
    last_d = last_q;
    sh_d   = sh_q;
    ack_d  = ack_q;
    if (accept) begin
      bit_d  = '0;
      last_d = 1'b0;
      sh_d   = payload;
      ack_d  = '0;
    end
    if (ack_sample) begin
      ack_d = {ack_q[1:ACK_BITS-1], miso};
    end
    if (hi_to_lo) begin
      if (bit_q == LAST_BIT) begin
        last_d = 1'b1;
      end else begin
        bit_d = bit_q + BW'(1);
        sh_d  = {sh_q[1:PAYLOAD_BITS-1], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q  <= '0;
      last_q <= 1'b0;
      ack_q  <= '0;
    end else begin
      bit_q  <= bit_d;
      last_q <= last_d;
      ack_q  <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign ack_word = ack_q;

`ifdef SPI_JOB_MASTER_ACK_CHECK_EN
  localparam logic [0:ACK_BITS-1] ACK_REF = ACK_BITS'(ACK_EXPECTED);

  logic err_q, err_d;

  // Verdict is taken as the frame closes and held until the next accepted job.
  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if ((state_q == ST_HOLD) && (state_d == ST_GAP)) begin
      err_d = (ack_q != ACK_REF);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ack_err = err_q;
`else
  assign ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_job_master.sv
// Directed bench for spi_job_master: full 768-bit frames at CLK_DIV=4 against a
// mode-0 slave model, plus an 8-bit CLK_DIV=1 instance.
module tb_spi_job_master;

`ifdef SPI_JOB_MASTER_ACK_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start, start_s;
  logic [0:767] payload;
  logic [0:7]   payload_s;
  logic         busy, done, cs_n, sclk, mosi, ack_err;
  logic         busy_s, done_s, cs_n_s, sclk_s, mosi_s, ack_err_s;
  logic         miso = 1'b0, miso_s = 1'b0;
  logic [0:7]   ack_word, ack_word_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_job_master u_dut (
    .clk(clk), .rst(rst), .start(start), .payload(payload),
    .busy(busy), .done(done), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .ack_word(ack_word), .ack_err(ack_err)
  );

  spi_job_master #(.PAYLOAD_BITS(8), .CLK_DIV(1), .ACK_BITS(8)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .payload(payload_s),
    .busy(busy_s), .done(done_s), .cs_n(cs_n_s), .sclk(sclk_s), .mosi(mosi_s),
    .miso(miso_s), .ack_word(ack_word_s), .ack_err(ack_err_s)
  );

  // Mode-0 slave: first reply bit on cs_n fall, next ones on sclk falls; mosi captured on rises.
  logic [7:0]   reply = 8'hA2;
  logic [0:767] rx;
  int           rises = 0, sidx = 0;
  logic         cs_prev = 1'b1, sclk_prev = 1'b0;

  always @(cs_n or sclk) begin
    if (cs_n == 1'b0 && cs_prev == 1'b1) begin
      rises = 0;
      sidx  = 0;
      miso  = reply[7];
    end
    if (sclk != sclk_prev) begin
      if (sclk) begin
        if (rises < 768) rx[rises] = mosi;
        rises++;
      end else begin
        sidx++;
        miso = (sidx < 8) ? reply[7 - sidx] : 1'b0;
      end
    end
    cs_prev   = cs_n;
    sclk_prev = sclk;
  end

  logic [7:0] reply_s = 8'hA2;
  logic [0:7] rx_s;
  int         rises_s = 0, sidx_s = 0;
  logic       cs_prev_s = 1'b1, sclk_prev_s = 1'b0;

  always @(cs_n_s or sclk_s) begin
    if (cs_n_s == 1'b0 && cs_prev_s == 1'b1) begin
      rises_s = 0;
      sidx_s  = 0;
      miso_s  = reply_s[7];
    end
    if (sclk_s != sclk_prev_s) begin
      if (sclk_s) begin
        if (rises_s < 8) rx_s[rises_s] = mosi_s;
        rises_s++;
      end else begin
        sidx_s++;
        miso_s = (sidx_s < 8) ? reply_s[7 - sidx_s] : 1'b0;
      end
    end
    cs_prev_s   = cs_n_s;
    sclk_prev_s = sclk_s;
  end

  task automatic check_eq(input string tag, input logic [767:0] got, input logic [767:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one frame from the start pulse; cycle n is n edges after the accepting edge.
  task automatic run_frame(input string pre, input logic [0:767] pl, input logic [7:0] rep,
                           input int pa, input int pb, input int rst_at,
                           output int dcyc, output int dcnt, output int bfall, output bit aborted);
    reply   = rep;
    dcyc    = -1;
    dcnt    = 0;
    bfall   = -1;
    aborted = 1'b0;
    @(negedge clk);
    payload = pl;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({pre, "_c1_busy"}, busy, 1'b1);
    check_eq({pre, "_c1_csn"}, cs_n, 1'b0);
    check_eq({pre, "_c1_mosi"}, mosi, pl[0]);
    check_eq({pre, "_c1_ackerr"}, ack_err, 1'b0);
    check_eq({pre, "_c1_ackword"}, ack_word, 8'h00);
    for (int n = 1; n < 7000; n++) begin
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        check_eq({pre, "_rst_csn"}, cs_n, 1'b1);
        check_eq({pre, "_rst_sclk"}, sclk, 1'b0);
        check_eq({pre, "_rst_busy"}, busy, 1'b0);
        check_eq({pre, "_rst_mosi"}, mosi, 1'b0);
        check_eq({pre, "_rst_done"}, done, 1'b0);
        check_eq({pre, "_rst_ackword"}, ack_word, 8'h00);
        repeat (5) @(negedge clk);
        rst     = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (done) begin
        dcnt++;
        dcyc = n;
      end
      if (!busy) begin
        bfall = n;
        break;
      end
      start = (n == pa || n == pb);
      if (n == pa) payload = ~pl;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_frame(input string pre, input logic [0:767] pl, input logic [7:0] rep,
                             input int dcyc, input int dcnt, input int bfall);
    check_eq({pre, "_rises"}, rises, 768);
    check_eq({pre, "_rx"}, rx, pl);
    check_eq({pre, "_ackword"}, ack_word, rep);
    check_eq({pre, "_done_cycle"}, dcyc, 6153);
    check_eq({pre, "_done_count"}, dcnt, 1);
    check_eq({pre, "_busy_fall"}, bfall, 6157);
    check_eq({pre, "_ackerr"}, ack_err, ERR_ON && (rep != 8'hA2));
  endtask

  logic [0:767] pl_a, pl_b;
  int           dcyc, dcnt, bfall, bad;
  bit           aborted;
  int           first_r, last_r, nr, sprev;

  initial begin
    for (int i = 0; i < 768; i++) begin
      pl_a[i] = (i % 2 == 0);
      pl_b[i] = ((i / 3) % 2 == 1);
    end
    rst = 1'b1; start = 1'b0; start_s = 1'b0; payload = '0; payload_s = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state, then 100 quiet cycles with no start.
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_csn", cs_n, 1'b1);
    check_eq("rst_sclk", sclk, 1'b0);
    check_eq("rst_mosi", mosi, 1'b0);
    check_eq("rst_ackword", ack_word, 8'h00);
    check_eq("rst_ackerr", ack_err, 1'b0);
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 ||
          ack_word !== 8'h00 || ack_err !== 1'b0 || cs_n_s !== 1'b1 || sclk_s !== 1'b0) bad++;
    end
    check_eq("idle_quiet", bad, 0);

    run_frame("A", pl_a, 8'hA2, -1, -1, -1, dcyc, dcnt, bfall, aborted);
    check_frame("A", pl_a, 8'hA2, dcyc, dcnt, bfall);

    run_frame("B", pl_a, 8'h5D, -1, -1, -1, dcyc, dcnt, bfall, aborted);
    check_frame("B", pl_a, 8'h5D, dcyc, dcnt, bfall);
    repeat (5) @(negedge clk);
    check_eq("B_ackerr_hold", ack_err, ERR_ON);

    // Starts at cycles 10 and 500 must be dropped; payload is also disturbed at cycle 10.
    run_frame("C", pl_a, 8'hA2, 10, 500, -1, dcyc, dcnt, bfall, aborted);
    check_frame("C", pl_a, 8'hA2, dcyc, dcnt, bfall);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_eq("C_no_second_frame", bad, 0);

    run_frame("D", pl_b, 8'hA2, -1, -1, -1, dcyc, dcnt, bfall, aborted);
    check_frame("D", pl_b, 8'hA2, dcyc, dcnt, bfall);

    run_frame("E", pl_a, 8'hA2, -1, -1, 3000, dcyc, dcnt, bfall, aborted);
    check_eq("E_aborted", aborted, 1'b1);
    check_eq("E_done_count", dcnt, 0);
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || cs_n !== 1'b1) bad++;
    end
    check_eq("E_quiet_after_rst", bad, 0);

    run_frame("F", pl_b, 8'hA2, -1, -1, -1, dcyc, dcnt, bfall, aborted);
    check_frame("F", pl_b, 8'hA2, dcyc, dcnt, bfall);

    // Small instance: 8 bits of 8'hC3 at one clk per half-period.
    @(negedge clk);
    payload_s = 8'hC3;
    start_s   = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    check_eq("S_c1_csn", cs_n_s, 1'b0);
    check_eq("S_c1_mosi", mosi_s, 1'b1);
    first_r = -1; last_r = -1; nr = 0; sprev = 0; dcyc = -1; dcnt = 0; bfall = -1;
    for (int n = 1; n < 100; n++) begin
      if (sclk_s && sprev == 0) begin
        nr++;
        if (first_r < 0) first_r = n;
        last_r = n;
      end
      sprev = sclk_s ? 1 : 0;
      if (done_s) begin
        dcnt++;
        dcyc = n;
      end
      if (!busy_s) begin
        bfall = n;
        break;
      end
      @(negedge clk);
    end
    check_eq("S_rises", nr, 8);
    check_eq("S_first_rise", first_r, 2);
    check_eq("S_last_rise", last_r, 16);
    check_eq("S_slave_rises", rises_s, 8);
    check_eq("S_rx", rx_s, 8'hC3);
    check_eq("S_ackword", ack_word_s, 8'hA2);
    check_eq("S_ackerr", ack_err_s, 1'b0);
    check_eq("S_done_cycle", dcyc, 19);
    check_eq("S_done_count", dcnt, 1);
    check_eq("S_busy_fall", bfall, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
